// File: rtl/fft_pkg.sv
// Shared types and helpers for the bit-reversing stream buffer and its reference models.
package fft_pkg;

  typedef logic bank_sel_t;

  localparam int FRAMES_MAX = 2;

  // Reverses the low nbits of idx; higher bits of the result are zero.
  function automatic int unsigned bitrev(input int unsigned idx, input int unsigned nbits);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < nbits; i++) begin
      r[i] = idx[nbits-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/bitrev_stream_buffer_index.sv
// Combinational index reverser on the read address path; zero latency, no handshake.
module bitrev_index
  import fft_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic [IDX_W-1:0] idx_i,
  output logic [IDX_W-1:0] idx_o
);

  assign idx_o = IDX_W'(bitrev(32'(idx_i), IDX_W));

endmodule

// File: rtl/bitrev_stream_buffer.sv
// Ping-pong frame buffer emitting each frame bit-reversed or in natural order.
// First output the cycle after a frame's last accept; in_ready drops only with both banks full.
module bitrev_stream_buffer
  import fft_pkg::*;
#(
  parameter int SAMPLES = 8,
  parameter int WIDTH   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             rev_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [1:0]       frames_held
);

  localparam int IDX_W = $clog2(SAMPLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES - 1);

  if (SAMPLES < 2 || (SAMPLES & (SAMPLES - 1)) != 0) begin : g_bad_samples
    $error("bitrev_stream_buffer: SAMPLES must be a power of 2 and at least 2");
  end

  bank_sel_t                wr_bank_q, wr_bank_d;
  bank_sel_t                rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]         wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]         rd_idx_q, rd_idx_d;
  logic [FRAMES_MAX-1:0]    full_q, full_d;
  logic [FRAMES_MAX-1:0]    bank_rev_q, bank_rev_d;
  logic [WIDTH-1:0]         mem_q [FRAMES_MAX][SAMPLES];

  logic                     wr_fire;
  logic                     rd_fire;
  logic [IDX_W-1:0]         rev_idx;
  logic [IDX_W-1:0]         rd_addr;

  assign in_ready  = !full_q[wr_bank_q] && !flush;
  assign out_valid = full_q[rd_bank_q];
  assign wr_fire   = in_valid && in_ready;
  // A read handshake during flush is dropped along with everything else.
  assign rd_fire   = out_valid && out_ready && !flush;

  always_comb begin
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    full_d     = full_q;
    bank_rev_d = bank_rev_q;
    if (flush) begin
      full_d    = '0;
      wr_idx_d  = '0;
      rd_idx_d  = '0;
      wr_bank_d = 1'b0;
      rd_bank_d = 1'b0;
    end else begin
      if (wr_fire) begin
        wr_idx_d = wr_idx_q + IDX_W'(1);
        if (wr_idx_q == '0) begin
          bank_rev_d[wr_bank_q] = rev_en;
        end
        if (wr_idx_q == LAST_IDX) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
        end
      end
      // Write and read banks always differ, so both updates to full_d can coexist.
      if (rd_fire) begin
        rd_idx_d = rd_idx_q + IDX_W'(1);
        if (rd_idx_q == LAST_IDX) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      full_q     <= '0;
      bank_rev_q <= '0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      full_q     <= full_d;
      bank_rev_q <= bank_rev_d;
    end
  end

  // Sample storage is plain flops without reset; validity is tracked by full_q alone.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_bank_q][wr_idx_q] <= in_data;
    end
  end

  bitrev_index #(.IDX_W(IDX_W)) u_rev (
    .idx_i (rd_idx_q),
    .idx_o (rev_idx)
  );

  assign rd_addr     = bank_rev_q[rd_bank_q] ? rev_idx : rd_idx_q;
  assign out_data    = out_valid ? mem_q[rd_bank_q][rd_addr] : '0;
  assign out_last    = out_valid && (rd_idx_q == LAST_IDX);
  assign frames_held = {1'b0, full_q[0]} + {1'b0, full_q[1]};

endmodule

// File: tb/tb_bitrev_stream_buffer.sv
// Directed and table-driven bench for bitrev_stream_buffer (8x3 and 16x8 instances).
module tb_bitrev_stream_buffer;
  import fft_pkg::*;

  logic clk;
  logic rst_n;

  logic       flush, rev_en, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [2:0] in_data, out_data;
  logic [1:0] frames_held;

  logic       b_flush, b_rev_en, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic [7:0] b_in_data, b_out_data;
  logic [1:0] b_frames_held;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct packed {
    logic            rev_first;
    logic            rev_rest;
    logic [0:7][2:0] din;
    logic [0:7][2:0] dout;
  } vec_t;

  vec_t tbl [6];

  logic [7:0] cur [16];
  int         widx = 0;
  logic       cur_rev = 1'b0;
  logic [7:0] expq [$];
  int         outs = 0;
  int         in_cnt = 0;
  logic [7:0] next_dat = 8'd0;

  bitrev_stream_buffer #(.SAMPLES(8), .WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .rev_en(rev_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .frames_held(frames_held)
  );

  bitrev_stream_buffer #(.SAMPLES(16), .WIDTH(8)) dut_big (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .rev_en(b_rev_en),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .frames_held(b_frames_held)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk(nm, {in_ready, out_valid, out_last, out_data, frames_held},
        {1'b1, 1'b0, 1'b0, 3'd0, 2'd0});
  endtask

  task automatic push_small(input logic [2:0] d, input logic r);
    in_valid = 1'b1;
    in_data  = d;
    rev_en   = r;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Entered and left at posedge+1.
  task automatic run_vec(input vec_t v, input int t);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = v.din[i];
      rev_en   = (i == 0) ? v.rev_first : v.rev_rest;
      @(negedge clk);
      if (i == 7) chk($sformatf("vec%0d out_valid before last accept", t), 32'(out_valid), 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("vec%0d out[%0d] {valid,last,data}", t, k),
          {out_valid, out_last, out_data}, {1'b1, (k == 7), v.dout[k]});
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk($sformatf("vec%0d drained", t), {out_valid, frames_held}, 3'b000);
    @(posedge clk); #1;
  endtask

  // Reference queue model for the 16x8 instance; called at the negedge before inputs are sampled.
  task automatic big_step();
    logic [7:0] e;
    chk("big frames_held", 32'(b_frames_held), 32'((expq.size() + 15) / 16));
    chk("big out_valid", 32'(b_out_valid), 32'(expq.size() != 0));
    if (b_out_valid && b_out_ready) begin
      if (expq.size() == 0) begin
        chk("big unexpected output", 32'(b_out_data), 32'hFFFF_FFFF);
      end else begin
        e = expq.pop_front();
        chk($sformatf("big out #%0d {last,data}", outs),
            {b_out_last, b_out_data}, {((outs % 16) == 15), e});
        outs++;
      end
    end
    if (b_in_valid && b_in_ready) begin
      if (widx == 0) cur_rev = b_rev_en;
      cur[widx] = b_in_data;
      widx++;
      in_cnt++;
      next_dat = next_dat + 8'd1;
      if (widx == 16) begin
        for (int k = 0; k < 16; k++) begin
          expq.push_back(cur_rev ? cur[bitrev(k, 4)] : cur[k]);
        end
        widx = 0;
      end
    end
  endtask

  initial begin
    int bub;
    int cyc;

    tbl[0].rev_first = 1'b1; tbl[0].rev_rest = 1'b1;
    tbl[0].din  = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    tbl[0].dout = {3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
    tbl[1].rev_first = 1'b0; tbl[1].rev_rest = 1'b0;
    tbl[1].din  = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    tbl[1].dout = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    tbl[2].rev_first = 1'b1; tbl[2].rev_rest = 1'b1;
    tbl[2].din  = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    tbl[2].dout = {3'd7, 3'd3, 3'd5, 3'd1, 3'd6, 3'd2, 3'd4, 3'd0};
    tbl[3].rev_first = 1'b1; tbl[3].rev_rest = 1'b0;
    tbl[3].din  = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    tbl[3].dout = {3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
    tbl[4].rev_first = 1'b0; tbl[4].rev_rest = 1'b1;
    tbl[4].din  = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    tbl[4].dout = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    tbl[5].rev_first = 1'b1; tbl[5].rev_rest = 1'b1;
    tbl[5].din  = {3'd5, 3'd5, 3'd0, 3'd0, 3'd7, 3'd7, 3'd2, 3'd2};
    tbl[5].dout = {3'd5, 3'd7, 3'd0, 3'd2, 3'd5, 3'd7, 3'd0, 3'd2};

    rst_n = 1'b0; flush = 1'b0; rev_en = 1'b0; in_valid = 1'b0; in_data = 3'd0; out_ready = 1'b0;
    b_flush = 1'b0; b_rev_en = 1'b0; b_in_valid = 1'b0; b_in_data = 8'd0; b_out_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("reset state");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 6; t++) run_vec(tbl[t], t);

    // Both banks full under backpressure, then ordered drain.
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      rev_en   = 1'b1;
      in_data  = (i < 8) ? 3'(i) : 3'(15 - i);
      @(negedge clk);
      chk($sformatf("bp in_ready before accept %0d", i), 32'(in_ready), 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp both full {in_ready,held,out_valid}", {in_ready, frames_held, out_valid}, {1'b0, 2'd2, 1'b1});
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("bp A[%0d] {valid,last,data,in_ready,held}", k),
          {out_valid, out_last, out_data, in_ready, frames_held},
          {1'b1, (k == 7), 3'(bitrev(k, 3)), 1'b0, 2'd2});
      @(posedge clk); #1;
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("bp B[%0d] {valid,last,data,in_ready,held}", k),
          {out_valid, out_last, out_data, in_ready, frames_held},
          {1'b1, (k == 7), 3'(7 - bitrev(k, 3)), 1'b1, 2'd1});
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk_idle("bp drained");
    @(posedge clk); #1;

    // Flush of a partial frame, with a concurrent input that must be ignored.
    for (int i = 0; i < 5; i++) push_small(3'(i + 2), 1'b1);
    in_valid = 1'b1; in_data = 3'd7; flush = 1'b1;
    @(negedge clk);
    chk("flush in_ready low", 32'(in_ready), 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk_idle("after partial flush");
    @(posedge clk); #1;
    run_vec(tbl[0], 10);

    // Flush with a complete frame held and a read handshake pending.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_small(3'(i), 1'b0);
    @(negedge clk);
    chk("pre-flush held", {out_valid, frames_held}, {1'b1, 2'd1});
    @(posedge clk); #1;
    out_ready = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk_idle("after full-frame flush");
    @(posedge clk); #1;
    run_vec(tbl[2], 12);

    // Reset pulse while draining.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_small(3'(7 - i), 1'b1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk_idle("reset during drain");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("after reset release");
    @(posedge clk); #1;
    run_vec(tbl[1], 13);

    // Streaming on the 16x8 instance: 4 back-to-back frames.
    bub = 0;
    b_out_ready = 1'b1;
    b_rev_en    = 1'b1;
    for (int c = 0; c < 80; c++) begin
      b_in_valid = (c < 64);
      b_in_data  = next_dat;
      @(negedge clk);
      if (c < 64 && !b_in_ready) bub++;
      if (c >= 16 && !b_out_valid) bub++;
      big_step();
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    chk("stream bubbles", 32'(bub), 0);
    chk("stream outputs", 32'(outs), 64);

    // Random handshakes, 200 frames.
    cyc = 0;
    while (outs < 64 + 3200 && cyc < 40000) begin
      b_in_valid  = (in_cnt < 64 + 3200) ? 1'($urandom_range(0, 1)) : 1'b0;
      b_in_data   = next_dat;
      b_rev_en    = 1'($urandom_range(0, 1));
      b_out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      big_step();
      @(posedge clk); #1;
      cyc++;
    end
    b_in_valid = 1'b0;
    chk("random outputs delivered", 32'(outs), 64 + 3200);
    chk("random leftover expected", 32'(expq.size()), 0);
    chk("random partial frame", 32'(widx), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
